// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter (CPU and debug/loader) in front of one synchronous memory port.
// Each access takes an ACCESS and a RESP cycle. Debug is granted after STARVE_LIMIT back-to-back CPU wins.
//
// state  | meaning
// IDLE   | no access in flight; arbitrate incoming requests
// ACCESS | grant and memory strobe for the latched winner
// RESP   | read data returned to owner; arbitrate the next request
module mem_port_arbiter #(
  parameter int STARVE_LIMIT = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       cpu_req,
  input  logic       cpu_we,
  input  logic [7:0] cpu_addr,
  input  logic [7:0] cpu_wdata,
  output logic       cpu_gnt,
  output logic       cpu_rvalid,
  output logic [7:0] cpu_rdata,
  input  logic       dbg_req,
  input  logic       dbg_we,
  input  logic [7:0] dbg_addr,
  input  logic [7:0] dbg_wdata,
  output logic       dbg_gnt,
  output logic       dbg_rvalid,
  output logic [7:0] dbg_rdata,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wdata,
  output logic       mem_wren,
  output logic       mem_rden,
  input  logic [7:0] mem_q,
  output logic       owner,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t     state_q, state_d;
  logic [3:0] starve_q, starve_d;
  logic       owner_q, owner_d;
  logic       we_q, we_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;
  logic [7:0] cpu_rdata_q, cpu_rdata_d;
  logic [7:0] dbg_rdata_q, dbg_rdata_d;
  logic       cpu_gnt_q, cpu_gnt_d;
  logic       dbg_gnt_q, dbg_gnt_d;
  logic       wren_q, wren_d;
  logic       rden_q, rden_d;
  logic       cpu_rvalid_q, cpu_rvalid_d;
  logic       dbg_rvalid_q, dbg_rvalid_d;
  logic       dbg_wins;

  // Reset masks every strobe combinationally so a reset cycle never touches memory.
  assign cpu_gnt    = cpu_gnt_q & ~reset;
  assign dbg_gnt    = dbg_gnt_q & ~reset;
  assign mem_wren   = wren_q & ~reset;
  assign mem_rden   = rden_q & ~reset;
  assign cpu_rvalid = cpu_rvalid_q & ~reset;
  assign dbg_rvalid = dbg_rvalid_q & ~reset;
  assign cpu_rdata  = cpu_rvalid ? mem_q : cpu_rdata_q;
  assign dbg_rdata  = dbg_rvalid ? mem_q : dbg_rdata_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign owner      = owner_q;
  assign busy       = (state_q != IDLE);

  always_comb begin
    state_d      = state_q;
    starve_d     = starve_q;
    owner_d      = owner_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    cpu_rdata_d  = cpu_rvalid ? mem_q : cpu_rdata_q;
    dbg_rdata_d  = dbg_rvalid ? mem_q : dbg_rdata_q;
    cpu_gnt_d    = 1'b0;
    dbg_gnt_d    = 1'b0;
    wren_d       = 1'b0;
    rden_d       = 1'b0;
    cpu_rvalid_d = 1'b0;
    dbg_rvalid_d = 1'b0;
    dbg_wins     = dbg_req & (~cpu_req | (starve_q == LIMIT));

    case (state_q)
      ACCESS: begin
        state_d      = RESP;
        cpu_rvalid_d = rden_q & ~owner_q;
        dbg_rvalid_d = rden_q & owner_q;
      end
      IDLE, RESP: begin
        if (cpu_req || dbg_req) begin
          state_d   = ACCESS;
          owner_d   = dbg_wins;
          we_d      = dbg_wins ? dbg_we    : cpu_we;
          addr_d    = dbg_wins ? dbg_addr  : cpu_addr;
          wdata_d   = dbg_wins ? dbg_wdata : cpu_wdata;
          cpu_gnt_d = ~dbg_wins;
          dbg_gnt_d = dbg_wins;
          wren_d    = we_d;
          rden_d    = ~we_d;
          if (dbg_wins) begin
            starve_d = 4'd0;
          end else if (dbg_req && (starve_q != LIMIT)) begin
            starve_d = starve_q + 4'd1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      starve_q     <= 4'd0;
      owner_q      <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= 8'h00;
      wdata_q      <= 8'h00;
      cpu_rdata_q  <= 8'h00;
      dbg_rdata_q  <= 8'h00;
      cpu_gnt_q    <= 1'b0;
      dbg_gnt_q    <= 1'b0;
      wren_q       <= 1'b0;
      rden_q       <= 1'b0;
      cpu_rvalid_q <= 1'b0;
      dbg_rvalid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      starve_q     <= starve_d;
      owner_q      <= owner_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      cpu_rdata_q  <= cpu_rdata_d;
      dbg_rdata_q  <= dbg_rdata_d;
      cpu_gnt_q    <= cpu_gnt_d;
      dbg_gnt_q    <= dbg_gnt_d;
      wren_q       <= wren_d;
      rden_q       <= rden_d;
      cpu_rvalid_q <= cpu_rvalid_d;
      dbg_rvalid_q <= dbg_rvalid_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and randomized checks of mem_port_arbiter against a cycle-count reference model
// that tracks "cycles since the last grant" plus an array image of memory.
module tb_mem_port_arbiter;

  localparam int LIMIT = 3;

  logic       clock = 1'b0;
  logic       reset;
  logic       cpu_req, cpu_we, dbg_req, dbg_we;
  logic [7:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata;
  logic       cpu_gnt, cpu_rvalid, dbg_gnt, dbg_rvalid;
  logic [7:0] cpu_rdata, dbg_rdata;
  logic [7:0] mem_addr, mem_wdata, mem_q;
  logic       mem_wren, mem_rden, owner, busy;

  always #5 clock = ~clock;

  mem_port_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clock(clock), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wren(mem_wren), .mem_rden(mem_rden),
    .mem_q(mem_q), .owner(owner), .busy(busy)
  );

  // Synchronous memory; preloaded on the first edge with i*7+3.
  logic [7:0] mem [256];
  bit         mem_loaded;
  always @(posedge clock) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'(i * 7 + 3);
      mem_loaded <= 1'b1;
    end else begin
      if (mem_wren) mem[mem_addr] <= mem_wdata;
      if (mem_rden) mem_q <= mem[mem_addr];
    end
  end

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: m_since counts cycles since a grant was shown (0 = grant cycle).
  logic [7:0] ref_mem [256];
  int         m_since = 99;
  int         m_starve = 0;
  logic       m_owner, m_we;
  logic [7:0] m_addr, m_wdata, m_cpu_rd, m_dbg_rd;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    logic dw;
    if (reset) begin
      m_since = 99; m_starve = 0; m_owner = 1'b0; m_we = 1'b0;
      m_addr = 8'h00; m_wdata = 8'h00; m_cpu_rd = 8'h00; m_dbg_rd = 8'h00;
    end else if (m_since == 0) begin
      if (m_we) ref_mem[m_addr] = m_wdata;
      else if (m_owner) m_dbg_rd = ref_mem[m_addr];
      else m_cpu_rd = ref_mem[m_addr];
      m_since = 1;
    end else if (cpu_req || dbg_req) begin
      dw = dbg_req && (!cpu_req || m_starve >= LIMIT);
      m_owner = dw;
      m_we    = dw ? dbg_we    : cpu_we;
      m_addr  = dw ? dbg_addr  : cpu_addr;
      m_wdata = dw ? dbg_wdata : cpu_wdata;
      if (dw) m_starve = 0;
      else if (dbg_req) m_starve = (m_starve + 1 > LIMIT) ? LIMIT : m_starve + 1;
      m_since = 0;
    end else if (m_since < 99) begin
      m_since++;
    end
  endtask

  task automatic check_all();
    logic acc, rsp;
    acc = (m_since == 0) && !reset;
    rsp = (m_since == 1) && !reset && !m_we;
    chk("cpu_gnt",    {7'd0, cpu_gnt},    {7'd0, acc && !m_owner});
    chk("dbg_gnt",    {7'd0, dbg_gnt},    {7'd0, acc && m_owner});
    chk("mem_wren",   {7'd0, mem_wren},   {7'd0, acc && m_we});
    chk("mem_rden",   {7'd0, mem_rden},   {7'd0, acc && !m_we});
    chk("mem_addr",   mem_addr,           m_addr);
    chk("mem_wdata",  mem_wdata,          m_wdata);
    chk("cpu_rvalid", {7'd0, cpu_rvalid}, {7'd0, rsp && !m_owner});
    chk("dbg_rvalid", {7'd0, dbg_rvalid}, {7'd0, rsp && m_owner});
    chk("cpu_rdata",  cpu_rdata,          m_cpu_rd);
    chk("dbg_rdata",  dbg_rdata,          m_dbg_rd);
    chk("owner",      {7'd0, owner},      {7'd0, m_owner});
    chk("busy",       {7'd0, busy},       {7'd0, m_since <= 1});
  endtask

  task automatic tick();
    model_edge();
    @(posedge clock);
    #1;
    check_all();
  endtask

  initial begin
    int k, cw, dw_cnt;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i * 7 + 3);
    reset = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 8'h00; cpu_wdata = 8'h00;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = 8'h00; dbg_wdata = 8'h00;
    tick(); tick();
    reset = 1'b0;
    tick();

    // Debug write 0x10 <= A5, then CPU read of 0x10.
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 8'h10; dbg_wdata = 8'hA5;
    tick();
    chk("dw_gnt", {7'd0, dbg_gnt}, 8'd1);
    dbg_req = 1'b0;
    tick();
    chk("dw_no_rvalid", {7'd0, dbg_rvalid}, 8'd0);
    tick();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h10;
    tick();
    chk("cr_gnt", {7'd0, cpu_gnt}, 8'd1);
    chk("cr_addr", mem_addr, 8'h10);
    chk("cr_rden", {7'd0, mem_rden}, 8'd1);
    cpu_req = 1'b0;
    tick();
    chk("cr_rvalid", {7'd0, cpu_rvalid}, 8'd1);
    chk("cr_rdata", cpu_rdata, 8'hA5);
    tick();
    chk("cr_hold", cpu_rdata, 8'hA5);

    // Debug write 0x20 <= 3C, then debug read back.
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 8'h20; dbg_wdata = 8'h3C;
    tick();
    chk("dw2_wren", {7'd0, mem_wren}, 8'd1);
    dbg_req = 1'b0;
    tick(); tick();
    dbg_req = 1'b1; dbg_we = 1'b0;
    tick();
    dbg_req = 1'b0;
    tick();
    chk("dr2_rdata", dbg_rdata, 8'h3C);
    tick();

    // Both requesters held: CPU x LIMIT then debug.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h01;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 8'h02;
    k = 0;
    for (int c = 0; c < 40 && k < 8; c++) begin
      tick();
      if (cpu_gnt || dbg_gnt) begin
        chk("starve_order", {7'd0, dbg_gnt}, {7'd0, (k % 4) == 3});
        k++;
      end
    end
    chk("starve_grants", 8'(k), 8'd8);
    cpu_req = 1'b0; dbg_req = 1'b0;
    tick(); tick();

    // Simultaneous single requests: CPU first, debug in the RESP arbitration.
    cpu_req = 1'b1; cpu_addr = 8'h40; dbg_req = 1'b1; dbg_addr = 8'h41;
    tick();
    chk("sim_cpu_first", {7'd0, cpu_gnt}, 8'd1);
    cpu_req = 1'b0;
    tick();
    chk("sim_cpu_rvalid", {7'd0, cpu_rvalid}, 8'd1);
    tick();
    chk("sim_dbg_second", {7'd0, dbg_gnt}, 8'd1);
    dbg_req = 1'b0;
    tick();
    chk("sim_dbg_rvalid", {7'd0, dbg_rvalid}, 8'd1);
    tick();

    // CPU pulse during a debug ACCESS is never served.
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 8'h50;
    tick();
    dbg_req = 1'b0; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h60;
    tick();
    cpu_req = 1'b0;
    tick();
    chk("pulse_no_gnt", {7'd0, cpu_gnt}, 8'd0);
    chk("pulse_idle", {7'd0, busy}, 8'd0);

    // Reset in the ACCESS cycle of a CPU write aborts it.
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h30; cpu_wdata = 8'h77;
    tick();
    reset = 1'b1;
    #1;
    chk("rst_wren", {7'd0, mem_wren}, 8'd0);
    chk("rst_gnt", {7'd0, cpu_gnt}, 8'd0);
    cpu_req = 1'b0;
    tick();
    chk("rst_busy", {7'd0, busy}, 8'd0);
    chk("rst_owner", {7'd0, owner}, 8'd0);
    reset = 1'b0;
    tick();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h30;
    tick();
    cpu_req = 1'b0;
    tick();
    chk("rst_no_write", cpu_rdata, 8'h53);
    tick();

    // Random traffic with protocol-abiding requesters and occasional reset.
    cw = 0; dw_cnt = 0;
    for (int it = 0; it < 400; it++) begin
      reset = ($urandom_range(0, 63) == 0);
      if (!cpu_req && $urandom_range(0, 2) == 0) begin
        cpu_req = 1'b1; cpu_we = 1'($urandom_range(0, 1));
        cpu_addr = 8'($urandom_range(0, 15)); cpu_wdata = 8'($urandom);
      end
      if (!dbg_req && $urandom_range(0, 3) == 0) begin
        dbg_req = 1'b1; dbg_we = 1'($urandom_range(0, 1));
        dbg_addr = 8'($urandom_range(0, 15)); dbg_wdata = 8'($urandom);
      end
      tick();
      cw = (cpu_req && !cpu_gnt) ? cw + 1 : 0;
      dw_cnt = (dbg_req && !dbg_gnt) ? dw_cnt + 1 : 0;
      chk("cpu_wait_bound", {7'd0, cw > 20}, 8'd0);
      chk("dbg_wait_bound", {7'd0, dw_cnt > 20}, 8'd0);
      if (cpu_gnt) begin
        cpu_req = 1'($urandom_range(0, 1));
        cpu_we = 1'($urandom_range(0, 1));
        cpu_addr = 8'($urandom_range(0, 15)); cpu_wdata = 8'($urandom);
      end
      if (dbg_gnt) begin
        dbg_req = 1'($urandom_range(0, 1));
        dbg_we = 1'($urandom_range(0, 1));
        dbg_addr = 8'($urandom_range(0, 15)); dbg_wdata = 8'($urandom);
      end
    end
    reset = 1'b0; cpu_req = 1'b0; dbg_req = 1'b0;
    tick(); tick(); tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
